// File: rtl/arc4_stream.sv
// arc4_stream: self-contained ARC4 (RC4) stream engine.
//
// Holds the 256-byte permutation S in registers, runs state init (256 cycles),
// key scheduling (256 cycles) and an optional drop-N discard phase, then XORs a
// ready/valid byte stream with the keystream at one byte per cycle.
//
// Ports:
//   clk_i        clock, all logic on rising edge
//   rst_i        synchronous active-high reset
//   en_i         start request, sampled only while rdy_o=1
//   key_i        key, byte 0 is the most significant byte
//   rdy_o        engine idle, accepts en_i
//   in_valid_i   input byte valid
//   in_ready_o   engine accepts input byte
//   in_data_i    plaintext/ciphertext byte
//   in_last_i    final byte of the message
//   out_valid_o  output byte valid
//   out_ready_i  downstream accepts output
//   out_data_o   in_data XOR keystream byte
//   out_last_o   in_last of this byte
module arc4_stream #(
  parameter int KEY_BYTES = 3,
  parameter int DROP_N    = 0
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   en_i,
  input  logic [KEY_BYTES*8-1:0] key_i,
  output logic                   rdy_o,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [7:0]             in_data_i,
  input  logic                   in_last_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [7:0]             out_data_o,
  output logic                   out_last_o
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_KSA   = 3'd2,
    ST_DROP  = 3'd3,
    ST_RUN   = 3'd4,
    ST_DRAIN = 3'd5
  } state_e;

  state_e                 state_q, state_d;
  logic [KEY_BYTES*8-1:0] key_q, key_d;
  logic [7:0]             i_q, i_d;
  logic [7:0]             j_q, j_d;
  logic [9:0]             drop_q, drop_d;
  logic                   out_valid_q, out_valid_d;
  logic [7:0]             out_data_q, out_data_d;
  logic                   out_last_q, out_last_d;

  // Permutation state; contents are don't-care after reset.
  logic [7:0]             s_q [256];

  // Two write ports are enough for a swap per cycle.
  logic                   wr_a_en_s, wr_b_en_s;
  logic [7:0]             wr_a_addr_s, wr_a_data_s;
  logic [7:0]             wr_b_addr_s, wr_b_data_s;

  // KSA datapath
  logic [7:0] kidx_s, key_byte_s, ksa_si_s, ksa_j_s, ksa_sj_s;
  // PRGA datapath
  logic [7:0] prga_i_s, prga_si_s, prga_j_s, prga_sj_s, prga_t_s, prga_k_s;

  logic in_ready_s, in_hs_s, out_hs_s;

  assign kidx_s = i_q % 8'(KEY_BYTES);

  // Select key byte (i mod KEY_BYTES), byte 0 being the MSB byte.
  always_comb begin
    key_byte_s = 8'd0;
    for (int n = 0; n < KEY_BYTES; n++) begin
      key_byte_s = (kidx_s == 8'(n)) ? key_q[KEY_BYTES*8-1-8*n -: 8] : key_byte_s;
    end
  end

  assign ksa_si_s = s_q[i_q];
  assign ksa_j_s  = j_q + ksa_si_s + key_byte_s;
  assign ksa_sj_s = s_q[ksa_j_s];

  assign prga_i_s  = i_q + 8'd1;
  assign prga_si_s = s_q[prga_i_s];
  assign prga_j_s  = j_q + prga_si_s;
  assign prga_sj_s = s_q[prga_j_s];
  assign prga_t_s  = prga_si_s + prga_sj_s;

  // Keystream byte read from the post-swap array: the two swapped slots are
  // forwarded so the step fits in one cycle.
  always_comb begin
    if (prga_t_s == prga_i_s) begin
      prga_k_s = prga_sj_s;
    end else if (prga_t_s == prga_j_s) begin
      prga_k_s = prga_si_s;
    end else begin
      prga_k_s = s_q[prga_t_s];
    end
  end

  assign in_ready_s = (state_q == ST_RUN) && (!out_valid_q || out_ready_i);
  assign in_hs_s    = in_valid_i && in_ready_s;
  assign out_hs_s   = out_valid_q && out_ready_i;

  // Next-state, datapath update and S write-port control.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    i_d         = i_q;
    j_d         = j_q;
    drop_d      = drop_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    wr_a_en_s   = 1'b0;
    wr_a_addr_s = 8'd0;
    wr_a_data_s = 8'd0;
    wr_b_en_s   = 1'b0;
    wr_b_addr_s = 8'd0;
    wr_b_data_s = 8'd0;

    case (state_q)
      ST_IDLE: begin
        if (en_i) begin
          key_d   = key_i;
          i_d     = 8'd0;
          j_d     = 8'd0;
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_INIT: begin
        wr_a_en_s   = 1'b1;
        wr_a_addr_s = i_q;
        wr_a_data_s = i_q;
        i_d         = i_q + 8'd1;
        if (i_q == 8'd255) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          state_d = ST_KSA;
        end else begin
          state_d = ST_INIT;
        end
      end

      ST_KSA: begin
        wr_a_en_s   = 1'b1;
        wr_a_addr_s = i_q;
        wr_a_data_s = ksa_sj_s;
        wr_b_en_s   = 1'b1;
        wr_b_addr_s = ksa_j_s;
        wr_b_data_s = ksa_si_s;
        i_d         = i_q + 8'd1;
        j_d         = ksa_j_s;
        if (i_q == 8'd255) begin
          i_d     = 8'd0;
          j_d     = 8'd0;
          drop_d  = 10'd0;
          state_d = (DROP_N > 0) ? ST_DROP : ST_RUN;
        end else begin
          state_d = ST_KSA;
        end
      end

      ST_DROP: begin
        wr_a_en_s   = 1'b1;
        wr_a_addr_s = prga_i_s;
        wr_a_data_s = prga_sj_s;
        wr_b_en_s   = 1'b1;
        wr_b_addr_s = prga_j_s;
        wr_b_data_s = prga_si_s;
        i_d         = prga_i_s;
        j_d         = prga_j_s;
        drop_d      = drop_q + 10'd1;
        if (drop_q == 10'(DROP_N - 1)) begin
          drop_d  = 10'd0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_RUN: begin
        if (in_hs_s) begin
          wr_a_en_s   = 1'b1;
          wr_a_addr_s = prga_i_s;
          wr_a_data_s = prga_sj_s;
          wr_b_en_s   = 1'b1;
          wr_b_addr_s = prga_j_s;
          wr_b_data_s = prga_si_s;
          i_d         = prga_i_s;
          j_d         = prga_j_s;
          out_data_d  = in_data_i ^ prga_k_s;
          out_valid_d = 1'b1;
          out_last_d  = in_last_i;
          state_d     = in_last_i ? ST_DRAIN : ST_RUN;
        end else if (out_hs_s) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = out_valid_q;
        end
      end

      ST_DRAIN: begin
        if (out_hs_s) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      i_q         <= 8'd0;
      j_q         <= 8'd0;
      drop_q      <= 10'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      i_q         <= i_d;
      j_q         <= j_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

  // S array writes. When both ports hit one address they carry the same value.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (wr_a_en_s) begin
        s_q[wr_a_addr_s] <= wr_a_data_s;
      end
      if (wr_b_en_s) begin
        s_q[wr_b_addr_s] <= wr_b_data_s;
      end
    end
  end

  assign rdy_o       = (state_q == ST_IDLE);
  assign in_ready_o  = in_ready_s;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign out_last_o  = out_last_q;

endmodule

// File: tb/tb_arc4_stream.sv
// Self-checking bench for arc4_stream: three instances (KEY_BYTES/DROP_N of
// 3/0, 4/0, 3/3), a scoreboard queue fed on input handshakes and a separate
// monitor that pops on output handshakes.
module tb_arc4_stream;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_s       [3];
  logic [31:0] key_s      [3];
  logic        rdy_s      [3];
  logic        in_valid_s [3];
  logic        in_ready_s [3];
  logic [7:0]  in_data_s  [3];
  logic        in_last_s  [3];
  logic        out_valid_s[3];
  logic        out_ready_s[3];
  logic [7:0]  out_data_s [3];
  logic        out_last_s [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int KB = (g == 1) ? 4 : 3;
    localparam int DN = (g == 2) ? 3 : 0;
    arc4_stream #(.KEY_BYTES(KB), .DROP_N(DN)) u_dut (
      .clk_i      (clk),
      .rst_i      (rst),
      .en_i       (en_s[g]),
      .key_i      (key_s[g][KB*8-1:0]),
      .rdy_o      (rdy_s[g]),
      .in_valid_i (in_valid_s[g]),
      .in_ready_o (in_ready_s[g]),
      .in_data_i  (in_data_s[g]),
      .in_last_i  (in_last_s[g]),
      .out_valid_o(out_valid_s[g]),
      .out_ready_i(out_ready_s[g]),
      .out_data_o (out_data_s[g]),
      .out_last_o (out_last_s[g])
    );
  end

  int         checks = 0;
  int         errors = 0;
  int         cur = 0;
  int         bp_mode = 0;   // 0: out_ready=1, 1: random, 2: out_ready=0
  logic [8:0] exp_q[$];
  logic [7:0] msg  [64];
  logic [7:0] exp_b[64];
  logic [7:0] ks   [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Textbook RC4 with optional drop, written straight from the algorithm.
  task automatic ref_ks(input logic [31:0] key, input int klen, input int drop, input int n);
    int s[256];
    int i, j, t, kb;
    for (int x = 0; x < 256; x++) s[x] = x;
    j = 0;
    for (int x = 0; x < 256; x++) begin
      kb = int'((key >> (8 * (klen - 1 - (x % klen)))) & 32'hFF);
      j = (j + s[x] + kb) % 256;
      t = s[x]; s[x] = s[j]; s[j] = t;
    end
    i = 0; j = 0;
    for (int x = 0; x < drop + n; x++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      if (x >= drop) ks[x - drop] = 8'(s[(s[i] + s[j]) % 256]);
    end
  endtask

  task automatic load(input logic [255:0] m, input logic [255:0] c, input int n);
    for (int b = 0; b < n; b++) begin
      msg[b]   = m[8*(n-1-b) +: 8];
      exp_b[b] = c[8*(n-1-b) +: 8];
    end
  endtask

  task automatic start(input int u, input logic [31:0] k, input int lat, input bit pulse);
    int cnt;
    bit seen;
    @(posedge clk); #1;
    chk("rdy_before_en", 32'(rdy_s[u]), 32'd1);
    key_s[u] = k;
    en_s[u]  = 1'b1;
    @(posedge clk); #1;
    en_s[u]  = 1'b0;
    key_s[u] = ~k;
    chk("rdy_after_en", 32'(rdy_s[u]), 32'd0);
    cnt = 0;
    seen = 1'b0;
    while (!seen && cnt < lat + 100) begin
      @(posedge clk);
      cnt++;
      #1;
      if (pulse && cnt == 300) begin
        en_s[u]  = 1'b1;
        key_s[u] = 32'h0;
      end else begin
        en_s[u] = 1'b0;
      end
      if (in_ready_s[u]) seen = 1'b1;
    end
    chk("in_ready_latency", 32'(cnt), 32'(lat));
  endtask

  task automatic send(input int u, input int first, input int n, input bit last,
                      input bit gaps, input int stall_at, input bit pulse);
    int  w;
    bit  hs;
    for (int b = first; b < n; b++) begin
      if (b == stall_at) begin
        in_valid_s[u] = 1'b0;
        repeat (50) @(posedge clk);
        #1;
      end
      while (gaps && $urandom_range(0, 2) == 0) begin
        in_valid_s[u] = 1'b0;
        @(posedge clk); #1;
      end
      in_valid_s[u] = 1'b1;
      in_data_s[u]  = msg[b];
      in_last_s[u]  = last && (b == n - 1);
      if (pulse && b == 4) begin
        en_s[u]  = 1'b1;
        key_s[u] = 32'hFFFF_FFFF;
      end
      hs = 1'b0;
      w  = 0;
      while (!hs && w < 200) begin
        @(negedge clk);
        if (in_ready_s[u]) begin
          hs = 1'b1;
          exp_q.push_back({in_last_s[u], exp_b[b]});
        end
        @(posedge clk); #1;
        w++;
      end
      en_s[u] = 1'b0;
      checks++;
      if (!hs) begin
        errors++;
        $display("FAIL in_handshake_timeout: byte %0d got no handshake, required one within 200 cycles", b);
      end
    end
    in_valid_s[u] = 1'b0;
    in_last_s[u]  = 1'b0;
  endtask

  task automatic wait_empty(input int u);
    int w;
    w = 0;
    while ((exp_q.size() != 0 || out_valid_s[u]) && w < 500) begin
      @(posedge clk); #1;
      w++;
    end
    checks++;
    if (w >= 500) begin
      errors++;
      $display("FAIL drain_timeout: %0d bytes outstanding, required 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Downstream ready driver, changed away from the stimulus instant.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      for (int g = 0; g < 3; g++) begin
        if (bp_mode == 0) out_ready_s[g] = 1'b1;
        else if (bp_mode == 1) out_ready_s[g] = 1'($urandom_range(0, 1));
        else out_ready_s[g] = 1'b0;
      end
    end
  end

  // Monitor: pops the scoreboard on each output handshake, checks hold while
  // stalled, and checks rdy one cycle after the last byte leaves.
  initial begin
    logic [8:0] e;
    logic       prev_stall;
    logic [7:0] pd;
    logic       pl;
    logic       chk_rdy;
    prev_stall = 1'b0;
    chk_rdy    = 1'b0;
    pd         = 8'd0;
    pl         = 1'b0;
    forever begin
      @(negedge clk);
      if (chk_rdy) begin
        chk("rdy_after_last", 32'(rdy_s[cur]), 32'd1);
        chk_rdy = 1'b0;
      end
      if (!rst && out_valid_s[cur]) begin
        if (prev_stall) begin
          chk("stall_data", 32'(out_data_s[cur]), 32'(pd));
          chk("stall_last", 32'(out_last_s[cur]), 32'(pl));
        end
        if (out_ready_s[cur]) begin
          prev_stall = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got byte %0h, required no output", out_data_s[cur]);
          end else begin
            e = exp_q.pop_front();
            chk("out_data", 32'(out_data_s[cur]), 32'(e[7:0]));
            chk("out_last", 32'(out_last_s[cur]), 32'(e[8]));
            if (e[8]) chk_rdy = 1'b1;
          end
        end else begin
          prev_stall = 1'b1;
          pd = out_data_s[cur];
          pl = out_last_s[cur];
        end
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  localparam logic [255:0] PT  = 256'h506C61696E74657874;
  localparam logic [255:0] CT  = 256'hBBF316E8D940AF0AD3;
  localparam logic [31:0]  KEY = 32'h004B6579;

  initial begin
    int          u, klen, drop;
    logic [31:0] rkey;
    rst = 1'b1;
    for (int g = 0; g < 3; g++) begin
      en_s[g] = 1'b0; key_s[g] = 32'h0; in_valid_s[g] = 1'b0;
      in_data_s[g] = 8'h0; in_last_s[g] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("reset_rdy", 32'(rdy_s[g]), 32'd1);
      chk("reset_in_ready", 32'(in_ready_s[g]), 32'd0);
      chk("reset_out_valid", 32'(out_valid_s[g]), 32'd0);
      chk("reset_out_data", 32'(out_data_s[g]), 32'd0);
      chk("reset_out_last", 32'(out_last_s[g]), 32'd0);
    end

    // "Key"/"Plaintext", en pulsed during KSA and during RUN.
    cur = 0;
    load(PT, CT, 9);
    start(0, KEY, 512, 1'b1);
    send(0, 0, 9, 1'b1, 1'b0, -1, 1'b1);
    wait_empty(0);

    // "Wiki"/"pedia" and decrypt round-trip.
    cur = 1;
    load(256'h7065646961, 256'h1021BF0420, 5);
    start(1, 32'h57696B69, 512, 1'b0);
    send(1, 0, 5, 1'b1, 1'b0, -1, 1'b0);
    wait_empty(1);
    load(256'h1021BF0420, 256'h7065646961, 5);
    start(1, 32'h57696B69, 512, 1'b0);
    send(1, 0, 5, 1'b1, 1'b0, -1, 1'b0);
    wait_empty(1);

    // Drop-3 with six zero bytes.
    cur = 2;
    load(256'h0, 256'h81B734CA72A7, 6);
    start(2, KEY, 515, 1'b0);
    send(2, 0, 6, 1'b1, 1'b0, -1, 1'b0);
    wait_empty(2);

    // Backpressure and input gaps.
    cur = 0;
    bp_mode = 1;
    load(PT, CT, 9);
    start(0, KEY, 512, 1'b0);
    send(0, 0, 9, 1'b1, 1'b1, -1, 1'b0);
    wait_empty(0);
    bp_mode = 0;

    // Reset mid-RUN with a pending output byte.
    start(0, KEY, 512, 1'b0);
    send(0, 0, 3, 1'b0, 1'b0, -1, 1'b0);
    wait_empty(0);
    bp_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    send(0, 3, 4, 1'b0, 1'b0, -1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_rdy", 32'(rdy_s[0]), 32'd1);
    chk("rst_mid_out_valid", 32'(out_valid_s[0]), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready_s[0]), 32'd0);
    exp_q.delete();
    bp_mode = 0;
    load(PT, CT, 9);
    start(0, KEY, 512, 1'b0);
    send(0, 0, 9, 1'b1, 1'b0, -1, 1'b0);
    wait_empty(0);

    // Random keys/data against the reference model; first trial stalls 50 cycles.
    for (int t = 0; t < 3; t++) begin
      u    = t;
      klen = (u == 1) ? 4 : 3;
      drop = (u == 2) ? 3 : 0;
      rkey = $urandom();
      if (klen == 3) rkey = rkey & 32'h00FF_FFFF;
      for (int b = 0; b < 20; b++) msg[b] = 8'($urandom_range(0, 255));
      ref_ks(rkey, klen, drop, 20);
      for (int b = 0; b < 20; b++) exp_b[b] = msg[b] ^ ks[b];
      cur = u;
      bp_mode = t % 2;
      start(u, rkey, 512 + drop, 1'b0);
      send(u, 0, 20, 1'b1, (t == 1), (t == 0) ? 8 : -1, 1'b0);
      wait_empty(u);
      bp_mode = 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/arc4_stream.md
Name: arc4_stream

Overview:
- Parametrised, self-contained ARC4 engine. Holds its own 256-byte state array in registers.
- Runs init, KSA and an optional RC4-dropN discard phase, then XORs a ready/valid byte stream with the keystream at one byte per cycle.
- Successor to the fixed 24-bit-key, memory-backed arc4 path. It adds variable key length, keystream drop, and streaming encrypt/decrypt, and is the engine for a future multi-channel cracker.

Parameters:
- KEY_BYTES, 3: key length in bytes (1..32).
- DROP_N, 0: number of keystream bytes discarded after KSA (0..1023).

Ports:
- clk       in   1               clock; all logic on rising edge
- rst       in   1               synchronous, active-high reset
- en        in   1               start request; sampled only while rdy=1
- key       in   KEY_BYTES*8     key; key byte n = key[KEY_BYTES*8-1-8n -: 8], big-endian, byte 0 is the MSB byte
- rdy       out  1               engine idle, accepts en
- in_valid  in   1               input byte valid
- in_ready  out  1               engine accepts input byte
- in_data   in   8               plaintext/ciphertext byte
- in_last   in   1               marks final input byte of message
- out_valid out  1               output byte valid
- out_ready in   1               downstream accepts output
- out_data  out  8               in_data XOR keystream byte
- out_last  out  1               copy of in_last for this byte

Behaviour:
- States: IDLE, INIT, KSA, DROP, RUN, DRAIN. rdy = (state==IDLE).
- Reset values: state IDLE, rdy=1, in_ready=0, out_valid=0, out_data=0, out_last=0, i=j=0, drop counter 0.
- rst has priority over everything. Reset mid-operation returns to IDLE on the next edge, drops any pending output byte, and leaves S contents don't-care.
- IDLE: when en=1 at an edge, latch key into an internal register, set i=0, go to INIT. en in any other state is ignored; later key changes are ignored.
- INIT: 256 cycles, S[i]=i, i=0..255. Then i=0, j=0, go to KSA.
- KSA: 256 cycles, one step per cycle. j = j + S[i] + keybyte[i mod KEY_BYTES] (mod 256); swap S[i],S[j]; i++.
- After KSA: i=j=0. Go to DROP if DROP_N>0, else RUN.
- DROP: DROP_N cycles. Each cycle does one PRGA step with the result discarded. Then go to RUN.
- PRGA step, single cycle:
  - i' = i+1; j' = j+S[i'].
  - Swap S[i'],S[j'].
  - k = S_after_swap[(S[i']+S[j']) mod 256]. The index sum is taken on pre-swap values; the read uses post-swap contents (forward the swapped values combinationally).
  - When i'==j' the swap is a no-op.
- Latency: en accepted at edge E0 → rdy=0 after E0 → in_ready first 1 after edge E(512+DROP_N).
- RUN: in_ready = (!out_valid || out_ready).
  - On input handshake: PRGA step; out_data <= in_data^k; out_valid <= 1; out_last <= in_last. Input-to-output latency is 1 cycle.
  - Output handshake with no input handshake in the same cycle: out_valid <= 0.
  - Simultaneous input and output handshake: new byte replaces old, out_valid stays 1. Sustained throughput is 1 byte/cycle with out_ready=1.
  - in_valid=0: no PRGA step; i, j and S hold.
  - Input handshake with in_last=1: go to DRAIN.
- DRAIN: in_ready=0. When out_valid&&out_ready: out_valid <= 0, go to IDLE (rdy=1 next cycle).
- out_data, out_last hold while out_valid=1 and out_ready=0.
- Arithmetic: all i, j and index sums are 8-bit and wrap mod 256. The drop counter is 10 bits.

Test Plan:
- KEY_BYTES=3, key=24'h4B6579 ("Key"), DROP_N=0. Stream "Plaintext" (50 6C 61 69 6E 74 65 78 74), in_last on the final byte, out_ready=1 → out_data BB F3 16 E8 D9 40 AF 0A D3; out_last only on D3; rdy=1 one cycle after the last out handshake. Check in_ready first rises exactly 512 edges after en accepted.
- KEY_BYTES=4, key=32'h57696B69 ("Wiki"). Input "pedia" (70 65 64 69 61) → 10 21 BF 04 20. Then restart with the same key and feed 10 21 BF 04 20 → 70 65 64 69 61 (decrypt round-trip).
- KEY_BYTES=3, key "Key", DROP_N=3. Input six 00 bytes → 81 B7 34 CA 72 A7. in_ready first high 515 edges after en.
- Backpressure: "Key"/"Plaintext" with out_ready toggled in a pseudo-random pattern and in_valid gaps → identical byte sequence. out_data stable while stalled; no byte lost or duplicated.
- en pulsed during KSA and during RUN → ignored, output unchanged. rst asserted mid-RUN → next cycle rdy=1, out_valid=0, in_ready=0. A fresh "Key" run then reproduces BB F3 16....
- in_valid=0 for 50 cycles mid-message → keystream does not advance; remaining bytes match the reference ciphertext.
